// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 encodings, FSM states,
// the latched request record and request-classification helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

  // Unsigned widths exist only for loads; reserved encodings are always rejected.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = write;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = lane[0];
      F3_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend and store byte merge. Halves use only
// lane[1] and words ignore the lane, so misaligned addresses align down here.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // load path: pick the addressed byte/half and extend it
  always_comb begin
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rdata = {24'd0, byte_s};
      F3_H:    rdata = {{16{half_s[15]}}, half_s};
      F3_HU:   rdata = {16'd0, half_s};
      F3_W:    rdata = word;
      default: rdata = 32'd0;
    endcase
  end

  // store path: overwrite only the addressed bytes of the current word
  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with valid/ready request and response channels.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned H/W accesses instead of aligning down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t        state_r;
  dmem_req_t     req_r;
  dmem_req_t     in_req_s;
  dmem_req_t     acc_req_s;
  logic [15:0]   cnt_r;
  logic [31:0]   mem_r [MEM_WORDS];
  logic [IW-1:0] idx_s;
  logic [31:0]   word_s;
  logic [31:0]   ld_data_s;
  logic [31:0]   st_data_s;
  logic [31:0]   rsp_data_s;
  logic          err_s;
  logic          do_access_s;

  assign in_req_s  = '{write: req_write, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign word_s    = mem_r[idx_s];

  // pick the request being serviced this cycle and classify it
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_req_s = in_req_s;
    end else begin
      acc_req_s = req_r;
    end
    idx_s = acc_req_s.addr[IW+1:2];
    err_s = ({2'b00, acc_req_s.addr[31:2]} >= 32'(MEM_WORDS)) ||
            f3_illegal(acc_req_s.write, acc_req_s.funct3);
`ifdef DMEM_MISALIGN_ERR_EN
    err_s = err_s || misaligned(acc_req_s.funct3, acc_req_s.addr[1:0]);
`endif
    if (state_r == ST_IDLE) begin
      do_access_s = req_valid && (WAIT_CYCLES == 0);
    end else if (state_r == ST_WAIT) begin
      do_access_s = (cnt_r == 16'd1);
    end else begin
      do_access_s = 1'b0;
    end
    if (err_s || acc_req_s.write) begin
      rsp_data_s = 32'd0;
    end else begin
      rsp_data_s = ld_data_s;
    end
  end

  dmem_lane_align u_align (
    .funct3 (acc_req_s.funct3),
    .lane   (acc_req_s.addr[1:0]),
    .word   (word_s),
    .wdata  (acc_req_s.wdata),
    .rdata  (ld_data_s),
    .merged (st_data_s)
  );

  // data array keeps its contents across rst; a store lands on the edge entering RESP
  always_ff @(posedge clk) begin
    if (!rst && do_access_s && acc_req_s.write && !err_s) begin
      mem_r[idx_s] <= st_data_s;
    end
  end

  // control FSM with wait counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      req_r      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_r <= in_req_s;
            cnt_r <= 16'(WAIT_CYCLES);
            state_r <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 16'd1;
          if (cnt_r == 16'd1) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r    <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if (do_access_s) begin
        resp_valid <= 1'b1;
        resp_rdata <= rsp_data_s;
        resp_err   <= err_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (MEM_WORDS=1024, WAIT_CYCLES=1);
// expectations follow DMEM_MISALIGN_ERR_EN when it is defined.
module tb_dmem_responder;

  localparam int MEM_WORDS   = 1024;
  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  dmem_responder #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, check latency and the popped expectation, hold resp_ready low
  // for 'hold' cycles, then complete the handshake.
  task automatic send(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee, input int hold);
    int n;
    logic [32:0] e;
    exp_q.push_back({ee, er});
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
    e = exp_q.pop_front();
    chk({tag, ".rdata"}, resp_rdata, e[31:0]);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, e[31:0]);
      chk({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".done_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] mis_data;
    logic        mis_err;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'b000; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.req_ready", {31'd0, req_ready}, 32'd1);

    send("st_w",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0,        1'b0, 0);
    send("ld_w",  1'b0, 32'h10, 32'd0,        3'b010, 32'hDEADBEEF, 1'b0, 0);
    send("st_b",  1'b1, 32'h13, 32'h00000080, 3'b000, 32'd0,        1'b0, 0);
    send("ld_b",  1'b0, 32'h13, 32'd0,        3'b000, 32'hFFFFFF80, 1'b0, 0);
    send("ld_bu", 1'b0, 32'h13, 32'd0,        3'b100, 32'h00000080, 1'b0, 0);
    send("ld_w2", 1'b0, 32'h10, 32'd0,        3'b010, 32'h80ADBEEF, 1'b0, 0);
    send("ld_hu", 1'b0, 32'h12, 32'd0,        3'b101, 32'h000080AD, 1'b0, 0);
    send("ld_h",  1'b0, 32'h12, 32'd0,        3'b001, 32'hFFFF80AD, 1'b0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    mis_data = 32'd0;        mis_err = 1'b1;
`else
    mis_data = 32'hFFFFBEEF; mis_err = 1'b0;
`endif
    send("ld_h_mis", 1'b0, 32'h11, 32'd0, 3'b001, mis_data, mis_err, 0);

    send("st_w14",  1'b1, 32'h14, 32'h11223344, 3'b010, 32'd0,        1'b0, 0);
    send("st_h16",  1'b1, 32'h16, 32'h0000BEEF, 3'b001, 32'd0,        1'b0, 0);
    send("ld_w14",  1'b0, 32'h14, 32'd0,        3'b010, 32'hBEEF3344, 1'b0, 0);

    send("st_w0",   1'b1, 32'h0,  32'hCAFEF00D, 3'b010, 32'd0,        1'b0, 0);
    send("st_oob",  1'b1, 32'(4 * MEM_WORDS), 32'h12345678, 3'b010, 32'd0, 1'b1, 0);
    send("ld_w0",   1'b0, 32'h0,  32'd0,        3'b010, 32'hCAFEF00D, 1'b0, 0);
    send("ld_f3_3", 1'b0, 32'h0,  32'd0,        3'b011, 32'd0,        1'b1, 0);
    send("st_bu",   1'b1, 32'h0,  32'h000000FF, 3'b100, 32'd0,        1'b1, 0);
    send("ld_w0b",  1'b0, 32'h0,  32'd0,        3'b010, 32'hCAFEF00D, 1'b0, 0);

    send("hold",    1'b0, 32'h14, 32'd0,        3'b010, 32'hBEEF3344, 1'b0, 5);

    // reset during the wait state of a store drops the store
    send("st_w20",  1'b1, 32'h20, 32'h00000000, 3'b010, 32'd0,        1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid.resp_valid2", {31'd0, resp_valid}, 32'd0);
    send("ld_w20", 1'b0, 32'h20, 32'd0, 3'b010, 32'h00000000, 1'b0, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the core's memory-access stage over a valid/ready request channel and a valid/ready response channel. Supports RISC-V byte/half/word widths with sign or zero extension on loads, byte-lane merging on stores, programmable wait states and error reporting. Sits between the core and the data RAM, replacing the zero-latency combinational data path so the core's MA state can stall on a real handshake.

## Interface
- MEM_WORDS, 1024: number of 32-bit words; valid word index range 0..MEM_WORDS-1.
- WAIT_CYCLES, 1: extra cycles between request acceptance and response; 0 is legal.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half/word used per width.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  request rejected, no memory side effect.

## Operation
- FSM states IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid: latch write/addr/wdata/funct3; if WAIT_CYCLES=0 → perform access, → RESP; else load wait counter with WAIT_CYCLES, → WAIT.
- WAIT: decrement counter each cycle; when counter=1 → perform access, → RESP.
- RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1 at an edge → IDLE. No new request accepted in the same cycle as the response handshake.
- Access: word index = addr[31:2]; lane = addr[1:0].
- Load: B/BU take byte at lane, H/HU take half at addr[1]; B/H sign-extend, BU/HU zero-extend, W whole word.
- Store: B/H/W only; only the addressed bytes change, other bytes of the word retain their value.
- Errors (resp_err=1, rdata=0, no write): word index ≥ MEM_WORDS; funct3 011/110/111; store with 100/101; misalignment (H with addr[0]=1, W with addr[1:0]≠0) per Configuration.
- Memory array is not cleared by rst; only FSM, counter, and output registers reset.

## Timing
- Reset values: req_ready=0 during the rst cycle, 1 in the first cycle after; resp_valid=0, resp_rdata=0, resp_err=0.
- Acceptance at edge N → resp_valid rises after edge N+1+WAIT_CYCLES−1, i.e. visible in cycle N+1+WAIT_CYCLES (WAIT_CYCLES=0: next cycle).
- Store committed to the array on the edge entering RESP; a load issued after the handshake sees it.
- Back-to-back: minimum request period WAIT_CYCLES+2 cycles with resp_ready held high.
- resp_ready low: RESP held indefinitely, outputs stable.
- rst mid-operation (WAIT or RESP): return to IDLE; an uncommitted store (still in WAIT) is dropped; a committed one persists.
- req_valid in non-IDLE states ignored.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: misaligned H/W accesses flagged with resp_err=1, no side effect.
- Not defined: misaligned addresses aligned down (addr[0] cleared for H, addr[1:0] cleared for W) and access proceeds normally, resp_err=0.

## Structure
- Package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, packed request struct (write, addr, wdata, funct3).
- Sub-module dmem_lane_align: combinational load extract/extend and store byte-merge from (funct3, addr[1:0], word, wdata); instantiated once.
- Top holds FSM, wait counter, latched request, memory array, response registers.

## Test plan
- WAIT_CYCLES=1: store W 0xDEADBEEF to 0x10, then load W 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after acceptance.
- Store B 0x80 to 0x13, load B 0x13 → 0xFFFFFF80; load BU 0x13 → 0x00000080; load W 0x10 → 0x80ADBEEF.
- Load H 0x11 with DMEM_MISALIGN_ERR_EN → resp_err=1, rdata=0; without macro → returns half at 0x10 (0xFFFFBEEF).
- Address 4*MEM_WORDS store → resp_err=1; subsequent load of word 0 unchanged; funct3=011 → resp_err=1.
- Hold resp_ready=0 for 5 cycles → resp_valid/rdata stable, req_ready=0; raise → IDLE next cycle.
- Assert rst during WAIT of a store to 0x20 (prior value 0x0) → IDLE, resp_valid=0, later load 0x20 → 0x00000000.
